rf_output_supervisor: RTL

RF_OUTPUT_SUPERVISOR -- requirements
Module: rf_output_supervisor

---
 rtl/rf_sup_pkg.sv | 23 ++
 rtl/rf_output_supervisor_gain_ramp.sv | 76 +++++++
 rtl/rf_output_supervisor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rf_sup_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_sup_pkg
// Purpose  : Shared types and widths for the RF output supervisor.
//            Holds the FSM state encoding plus state and gain widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rf_sup_pkg;

  localparam int STATE_W = 3;
  localparam int GAIN_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

endpackage : rf_sup_pkg
`default_nettype wire

// File: rtl/rf_output_supervisor_gain_ramp.sv
`default_nettype none
// ============================================================================
// Module   : gain_ramp
// Purpose  : Step prescaler plus saturating up/down gain counter.
//            The mode inputs describe the state the FSM is entering on this
//            clock, so a change of mode restarts the prescaler at 0.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            up, down        - ramp direction for the coming cycle
//            hold_zero       - force gain and prescaler to 0
//            gain            - registered gain value
//            at_max, at_zero - gain is at 255 / at 0
// Revision : 1.0 - initial release
// ============================================================================
module gain_ramp
  import rf_sup_pkg::*;
#(
  parameter int STEP_CYCLES = 1250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up,
  input  logic              down,
  input  logic              hold_zero,
  output logic [GAIN_W-1:0] gain,
  output logic              at_max,
  output logic              at_zero
);

  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] c_PRESC_LAST = PW'(STEP_CYCLES - 1);

  logic [PW-1:0]     r_presc;
  logic [GAIN_W-1:0] r_gain;
  logic [1:0]        r_mode;
  logic [1:0]        w_mode;
  logic              w_step;

  assign w_mode = {up, down};
  assign w_step = (r_presc == c_PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_gain  <= '0;
      r_mode  <= 2'b00;
    end else begin
      r_mode <= w_mode;
      if (hold_zero) begin
        r_presc <= '0;
        r_gain  <= '0;
      end else if (w_mode != r_mode) begin
        // Entering a new state: restart the step timer, keep the gain.
        r_presc <= '0;
      end else if (up || down) begin
        if (w_step) begin
          r_presc <= '0;
          if (up && (r_gain != {GAIN_W{1'b1}})) begin
            r_gain <= r_gain + GAIN_W'(1);
          end else if (down && (r_gain != '0)) begin
            r_gain <= r_gain - GAIN_W'(1);
          end
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end else begin
        r_presc <= '0;
      end
    end
  end

  assign gain    = r_gain;
  assign at_max  = (r_gain == {GAIN_W{1'b1}});
  assign at_zero = (r_gain == '0);

endmodule : gain_ramp
`default_nettype wire

// File: rtl/rf_output_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : rf_output_supervisor
// Purpose  : Arms/disarms the RF DAC output with gain ramps, feeds the
//            external watchdog and latches watchdog faults.
// Ports    : clk, rst                      - clock, sync active-high reset
//            arm, disarm, clear            - one-cycle host requests
//            hb_req[1:0], hb_src_en[1:0]   - heartbeat pulses and mask
//            wd_triggered, wd_warning      - watchdog status inputs
//            wd_enable, wd_heartbeat,
//            wd_force_reset                - watchdog controls
//            rf_enable, rf_gain[7:0]       - RF DAC controls
//            state[2:0], warn, fault,
//            fault_count[7:0]              - status
// Revision : 1.0 - initial release
// ============================================================================
module rf_output_supervisor
  import rf_sup_pkg::*;
#(
  parameter int CLK_FREQ    = 125_000_000,
  parameter int STEP_CYCLES = 1250
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               disarm,
  input  logic               clear,
  input  logic [1:0]         hb_req,
  input  logic [1:0]         hb_src_en,
  input  logic               wd_triggered,
  input  logic               wd_warning,
  output logic               wd_enable,
  output logic               wd_heartbeat,
  output logic               wd_force_reset,
  output logic               rf_enable,
  output logic [GAIN_W-1:0]  rf_gain,
  output logic [STATE_W-1:0] state,
  output logic               warn,
  output logic               fault,
  output logic [7:0]         fault_count
);

  state_t            r_state;
  state_t            w_next;
  logic              r_fault_pend;
  logic              r_wd_en;
  logic              r_hb;
  logic              r_force;
  logic              r_rf_en;
  logic              r_warn;
  logic              r_fault;
  logic [7:0]        r_fault_count;
  logic [GAIN_W-1:0] w_gain;
  logic              w_at_max;
  logic              w_at_zero;
  logic              w_wd_en_next;
  logic              w_rf_en_next;
  logic              w_up;
  logic              w_down;
  logic              w_hold_zero;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (arm) w_next = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (wd_triggered || disarm) w_next = ST_RAMP_DOWN;
        else if (w_at_max)          w_next = ST_RUN;
      end
      ST_RUN: begin
        if (wd_triggered || disarm) w_next = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (w_at_zero) w_next = r_fault_pend ? ST_FAULT : ST_IDLE;
      end
      ST_FAULT: begin
        if (clear) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every
  // output changes on the same edge as the state code.
  assign w_wd_en_next = (w_next == ST_RAMP_UP) || (w_next == ST_RUN);
  assign w_rf_en_next = w_wd_en_next || (w_next == ST_RAMP_DOWN);
  assign w_up         = (w_next == ST_RAMP_UP);
  assign w_down       = (w_next == ST_RAMP_DOWN);
  assign w_hold_zero  = (w_next == ST_IDLE) || (w_next == ST_FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_en       <= 1'b0;
      r_rf_en       <= 1'b0;
      r_hb          <= 1'b0;
      r_warn        <= 1'b0;
      r_force       <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_count <= 8'd0;
      r_fault_pend  <= 1'b0;
    end else begin
      r_wd_en <= w_wd_en_next;
      r_rf_en <= w_rf_en_next;
      r_hb    <= w_wd_en_next & (|(hb_req & hb_src_en));
      r_warn  <= w_wd_en_next & wd_warning;
      r_force <= (r_state == ST_FAULT) && (w_next == ST_IDLE);
      r_fault <= (w_next == ST_FAULT);
      if ((w_next == ST_FAULT) && (r_state != ST_FAULT) && (r_fault_count != 8'hFF)) begin
        r_fault_count <= r_fault_count + 8'd1;
      end
      // fault_pend remembers why the ramp-down started.
      case (r_state)
        ST_RAMP_UP, ST_RUN: begin
          if (wd_triggered)  r_fault_pend <= 1'b1;
          else if (disarm)   r_fault_pend <= 1'b0;
        end
        ST_RAMP_DOWN: begin
          if (w_at_zero) r_fault_pend <= 1'b0;
        end
        default: r_fault_pend <= 1'b0;
      endcase
    end
  end

  // ------------------------------------------------------- gain ramp
  // A non-positive step count or clock rate is not a usable build; the
  // fallback parks the gain at zero so the RF stage stays silent.
  if ((STEP_CYCLES >= 1) && (CLK_FREQ > 0)) begin : g_ramp_ok
    gain_ramp #(
      .STEP_CYCLES (STEP_CYCLES)
    ) u_gain_ramp (
      .clk       (clk),
      .rst       (rst),
      .up        (w_up),
      .down      (w_down),
      .hold_zero (w_hold_zero),
      .gain      (w_gain),
      .at_max    (w_at_max),
      .at_zero   (w_at_zero)
    );
  end else begin : g_ramp_bad
    assign w_gain    = '0;
    assign w_at_max  = 1'b0;
    assign w_at_zero = 1'b1;
  end

  assign state          = r_state;
  assign rf_gain        = w_gain;
  assign rf_enable      = r_rf_en;
  assign wd_enable      = r_wd_en;
  assign wd_heartbeat   = r_hb;
  assign wd_force_reset = r_force;
  assign warn           = r_warn;
  assign fault          = r_fault;
  assign fault_count    = r_fault_count;

endmodule : rf_output_supervisor
`default_nettype wire
